dte_req_queue: RTL and testbench
================================

Name: dte_req_queue

Overview:
- Timed request sequencer directly upstream of the DTE front-end stage.
- Buffers timestamped front-end requests: diag function, diag read, diag write, misc and release-EBUS-data.
- Releases each request, in order, once the 60 ns EBUS tick count reaches its timestamp. Hands it to the DTE over valid/ready, then captures the DTE's reply word for the producer.
- Replaces the software-side pending/get/reply polling with a synthesizable, bench-observable queue.

Parameters:
- DEPTH, 8: FIFO entries, power of two, ≥2.
- TIMEOUT, 1024: reply-wait limit in ticks; used only with the optional feature.

Ports:
- clk  in  1  EBUS clock; one tick per rising edge.
- reset  in  1  asynchronous, active-high.
- push_valid  in  1  producer offers a request.
- push_ready  out  1  queue can accept (not full).
- push_time  in  64  release tick, unsigned.
- push_type  in  3  tFEReqType.
- push_diag  in  7  diag function / misc code.
- push_data  in  36 [0:35]  write data.
- req_valid  out  1  request presented to DTE.
- req_ready  in  1  DTE accepts.
- req_type  out  3  presented request type.
- req_diag  out  7  presented diag function / misc code.
- req_data  out  36  presented write data.
- rsp_valid  in  1  DTE reply strobe, single cycle.
- rsp_data  in  36  EBUS data sampled by DTE.
- rep_valid  out  1  reply held for producer.
- rep_ack  in  1  producer consumes reply.
- rep_time  out  64  reply tick.
- rep_type  out  3  reply request type.
- rep_diag  out  7  reply diag code.
- rep_data  out  36  reply data.
- ticks  out  64  free-running tick count.
- count  out  $clog2(DEPTH+1)  occupancy.
- timeout  out  1  sticky reply-timeout flag.

Behaviour:
- Reset (async, any state): all outputs 0 except push_ready=1. FIFO emptied; ticks=0; state S_IDLE; timeout cleared. Any in-flight request is dropped with no reply.
- ticks: +1 every edge; wraps modulo 2^64 with no special handling.
- Push: accepted on an edge with push_valid && push_ready. push_ready = (count != DEPTH), registered. A same-cycle pop does not admit a push when full. Payload is opaque; types pass through unchecked.
- Due condition: head.time <= ticks, unsigned compare. Past timestamps are due immediately. Strict FIFO order: a not-yet-due head blocks later due entries.
- S_IDLE: if count>0, head due, and (rep_valid==0 or rep_ack this cycle), go to S_ISSUE. Load req_* from the head and set req_valid.
- Latency: push of an already-due request into an empty queue with no held reply gives req_valid high 2 edges after the push edge.
- S_ISSUE: req_valid=1, req_* stable until req_ready. On the handshake edge, pop FIFO, clear req_valid, latch type/diag, go to S_REPLY.
- S_REPLY: on rsp_valid, load rep_data=rsp_data, rep_time=ticks, rep_type/rep_diag from the latch. Set rep_valid and go to S_IDLE.
  - rsp_valid in any other state is ignored.
- Reply register: rep_valid holds until rep_ack. rep_ack with rep_valid=0 has no effect.
  - Entry to S_ISSUE is gated on a free register, so a reply is never overwritten.
- One outstanding request at most.
- count updates on push/pop edges. Simultaneous push and pop leaves count unchanged.

Optional Feature:
- Macro: DTE_REQ_TIMEOUT_EN.
- With it: a wait counter clears on S_REPLY entry and counts each edge in S_REPLY.
  - On reaching TIMEOUT with no rsp_valid, synthesize a reply with rep_data=0, set timeout=1 (sticky until reset), and return to S_IDLE.
  - rsp_valid on the same edge as expiry wins: normal reply, no flag.
- Without it: S_REPLY waits indefinitely; timeout tied 0.

Decomposition:
- Package dte_pkg:
  - tFEReqType as a 3-bit enum: dteNone, dteDiagFunc, dteDiagRead, dteDiagWrite, dteMisc, dteReleaseEBUSData.
  - tDteReq packed struct {time, type, diag, data}.
  - state enum {S_IDLE, S_ISSUE, S_REPLY}.
- Sub-module dte_req_fifo: generic synchronous FIFO of tDteReq with async reset, full/empty/count, and head always visible.

Test Plan:
- Due-now request: at ticks=5, push time=0, dteDiagFunc, diag=7'o71. Expect:
  - req_valid 2 edges later; req_ready=1 pops it.
  - rsp_data=36'o123456654321 gives rep_valid=1, rep_type=dteDiagFunc, rep_diag=7'o71, that data, and rep_time=ticks at capture.
- Future release: push time=100. Expect req_valid low while ticks<100, first high the cycle after ticks reads 100.
- Full queue: DEPTH=8, 8 pushes of time=0 with req_ready=0. Expect:
  - count=8, push_ready=0; a 9th push is not accepted.
  - Draining returns all 8 in push order.
- Reply backpressure: hold rep_valid unacked with a due head. Expect req_valid stays 0; rep_ack lets req_valid rise within 1 edge.
- Reset mid-operation: assert reset in S_REPLY. Expect immediately (no edge) rep_valid=0, req_valid=0, count=0, ticks=0, push_ready=1; a later rsp_valid is ignored.
- With DTE_REQ_TIMEOUT_EN, TIMEOUT=16, no rsp_valid. Expect rep_valid with rep_data=0 and timeout=1, 16 edges after S_REPLY entry; the next request still issues.

Source files
------------

// File: rtl/dte_req_queue_pkg.sv
// Shared types for the DTE request queue: request codes,
// the queued request bundle and the sequencer states.
package dte_pkg;

    typedef enum logic [2:0] {
        dteNone,
        dteDiagFunc,
        dteDiagRead,
        dteDiagWrite,
        dteMisc,
        dteReleaseEBUSData
    } tFEReqType;

    typedef struct packed {
        logic [63:0] reqTime;
        tFEReqType   reqType;
        logic [6:0]  reqDiag;
        logic [0:35] reqData;
    } tDteReq;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_REPLY
    } tState;

endpackage

// File: rtl/dte_req_queue_if.sv
// Producer / DTE / reply bundle of the DTE request queue.
// slave is the queue side, master the producer and DTE side.
interface dte_req_queue_if
    import dte_pkg::*;
#(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          push_valid;
    logic          push_ready;
    logic [63:0]   push_time;
    tFEReqType     push_type;
    logic [6:0]    push_diag;
    logic [0:35]   push_data;

    logic          req_valid;
    logic          req_ready;
    tFEReqType     req_type;
    logic [6:0]    req_diag;
    logic [0:35]   req_data;

    logic          rsp_valid;
    logic [0:35]   rsp_data;

    logic          rep_valid;
    logic          rep_ack;
    logic [63:0]   rep_time;
    tFEReqType     rep_type;
    logic [6:0]    rep_diag;
    logic [0:35]   rep_data;

    logic [63:0]   ticks;
    logic [CW-1:0] count;
    logic          timeout;

    modport slave (
        input  push_valid, push_time, push_type,
        input  push_diag, push_data,
        output push_ready,
        output req_valid, req_type, req_diag, req_data,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rep_valid, rep_time, rep_type,
        output rep_diag, rep_data,
        input  rep_ack,
        output ticks, count, timeout
    );

    modport master (
        output push_valid, push_time, push_type,
        output push_diag, push_data,
        input  push_ready,
        input  req_valid, req_type, req_diag, req_data,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rep_valid, rep_time, rep_type,
        input  rep_diag, rep_data,
        output rep_ack,
        input  ticks, count, timeout
    );
endinterface

// File: rtl/dte_req_fifo.sv
// Synchronous FIFO of tDteReq with async reset.
// The head entry is always visible on head.
module dte_req_fifo
    import dte_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pushEn,
    input  tDteReq        pushData,
    input  logic          popEn,
    output tDteReq        head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    tDteReq        mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = pushEn && !full;
    assign doPop  = popEn && !empty;
    assign head   = mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/dte_req_queue.sv
// Timed DTE request sequencer; optional reply timeout
// is enabled with the DTE_REQ_TIMEOUT_EN macro.
module dte_req_queue
    import dte_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input logic            clk,
    input logic            reset,
    dte_req_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    tState         state;
    tState         stateNext;
    tDteReq        head;
    tDteReq        pushReq;
    logic          empty;
    logic          unusedFull;
    logic [CW-1:0] fifoCount;
    logic [CW-1:0] countNext;
    logic          doPush;
    logic          doPop;
    logic          issueGo;
    logic          replyGo;
    logic          expire;
    logic          dueQ;
    logic          pushReady;
    logic [63:0]   ticks;

    logic          reqValid;
    tFEReqType     reqType;
    logic [6:0]    reqDiag;
    logic [0:35]   reqData;
    tFEReqType     typeQ;
    logic [6:0]    diagQ;

    logic          repValid;
    logic [63:0]   repTime;
    tFEReqType     repType;
    logic [6:0]    repDiag;
    logic [0:35]   repData;

    assign pushReq = '{
        reqTime: bus.push_time,
        reqType: bus.push_type,
        reqDiag: bus.push_diag,
        reqData: bus.push_data
    };
    assign doPush    = bus.push_valid && pushReady;
    assign countNext = fifoCount + CW'(doPush) - CW'(doPop);

    dte_req_fifo #(.DEPTH(DEPTH)) fifo (
        .clk      (clk),
        .reset    (reset),
        .pushEn   (doPush),
        .pushData (pushReq),
        .popEn    (doPop),
        .head     (head),
        .full     (unusedFull),
        .empty    (empty),
        .count    (fifoCount)
    );

`ifdef DTE_REQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] waitCnt;
    logic          timeoutQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt  <= '0;
            timeoutQ <= 1'b0;
        end else begin
            if (doPop) waitCnt <= '0;
            else if (state == S_REPLY) waitCnt <= waitCnt + 1'b1;
            if (expire) timeoutQ <= 1'b1;
        end
    end

    assign bus.timeout = timeoutQ;
`else
    logic unusedTimeout;

    assign unusedTimeout = ^TIMEOUT;
    assign bus.timeout   = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        issueGo   = 1'b0;
        doPop     = 1'b0;
        replyGo   = 1'b0;
        expire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty && dueQ && (!repValid || bus.rep_ack)) begin
                    issueGo   = 1'b1;
                    stateNext = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.req_ready) begin
                    doPop     = 1'b1;
                    stateNext = S_REPLY;
                end
            end
            S_REPLY: begin
                if (bus.rsp_valid) begin
                    replyGo   = 1'b1;
                    stateNext = S_IDLE;
`ifdef DTE_REQ_TIMEOUT_EN
                end else if (waitCnt == WW'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    stateNext = S_IDLE;
`endif
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Due compare is registered against the tick value of the
    // next cycle, keeping the 64-bit compare off the issue path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ticks     <= '0;
            dueQ      <= 1'b0;
            pushReady <= 1'b1;
            reqValid  <= 1'b0;
            reqType   <= dteNone;
            reqDiag   <= '0;
            reqData   <= '0;
            typeQ     <= dteNone;
            diagQ     <= '0;
            repValid  <= 1'b0;
            repTime   <= '0;
            repType   <= dteNone;
            repDiag   <= '0;
            repData   <= '0;
        end else begin
            state     <= stateNext;
            ticks     <= ticks + 64'd1;
            dueQ      <= !empty && (head.reqTime <= ticks + 64'd1);
            pushReady <= (countNext != CW'(DEPTH));
            if (issueGo) begin
                reqValid <= 1'b1;
                reqType  <= head.reqType;
                reqDiag  <= head.reqDiag;
                reqData  <= head.reqData;
            end
            if (doPop) begin
                reqValid <= 1'b0;
                typeQ    <= reqType;
                diagQ    <= reqDiag;
            end
            if (replyGo || expire) begin
                repValid <= 1'b1;
                repTime  <= ticks;
                repType  <= typeQ;
                repDiag  <= diagQ;
                repData  <= replyGo ? bus.rsp_data : '0;
            end else if (bus.rep_ack) begin
                repValid <= 1'b0;
            end
        end
    end

    assign bus.push_ready = pushReady;
    assign bus.req_valid  = reqValid;
    assign bus.req_type   = reqType;
    assign bus.req_diag   = reqDiag;
    assign bus.req_data   = reqData;
    assign bus.rep_valid  = repValid;
    assign bus.rep_time   = repTime;
    assign bus.rep_type   = repType;
    assign bus.rep_diag   = repDiag;
    assign bus.rep_data   = repData;
    assign bus.ticks      = ticks;
    assign bus.count      = fifoCount;
endmodule

// File: tb/tb_dte_req_queue.sv
// Scoreboard bench for dte_req_queue; the timeout section
// runs when DTE_REQ_TIMEOUT_EN is defined.
module tb_dte_req_queue;
    import dte_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] mTicks;
    int          nChk  = 0;
    int          nPass = 0;
    tDteReq      sb[$];
    tDteReq      eTmo;
    bit          early;
    bit          held;

    dte_req_queue_if #(.DEPTH(DEPTH)) bus ();

    dte_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) mTicks <= '0;
        else mTicks <= mTicks + 64'd1;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] t,
                        input tFEReqType ty,
                        input logic [6:0] dg,
                        input logic [0:35] dt,
                        input bit expOk);
        bus.push_valid = 1'b1;
        bus.push_time  = t;
        bus.push_type  = ty;
        bus.push_diag  = dg;
        bus.push_data  = dt;
        step();
        bus.push_valid = 1'b0;
        if (expOk) sb.push_back('{t, ty, dg, dt});
    endtask

    task automatic waitReq(input int budget);
        int n = 0;
        while (!bus.req_valid && n < budget) begin
            step();
            n++;
        end
        check("reqValidWait", 64'(bus.req_valid), 1);
    endtask

    task automatic serve(input logic [0:35] rsp, input bit ack);
        tDteReq      e;
        logic [63:0] capT;
        waitReq(64);
        check("sbHasEntry", 64'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("reqType", 64'(bus.req_type), 64'(e.reqType));
        check("reqDiag", 64'(bus.req_diag), 64'(e.reqDiag));
        check("reqData", 64'(bus.req_data), 64'(e.reqData));
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        check("reqDrop", 64'(bus.req_valid), 0);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rsp;
        capT = mTicks;
        step();
        bus.rsp_valid = 1'b0;
        check("repValid", 64'(bus.rep_valid), 1);
        check("repType", 64'(bus.rep_type), 64'(e.reqType));
        check("repDiag", 64'(bus.rep_diag), 64'(e.reqDiag));
        check("repData", 64'(bus.rep_data), 64'(rsp));
        check("repTime", bus.rep_time, capT);
        if (ack) begin
            bus.rep_ack = 1'b1;
            step();
            bus.rep_ack = 1'b0;
            check("repClr", 64'(bus.rep_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got stall want finish");
        $fatal(1);
    end

    initial begin
        bus.push_valid = 1'b0;
        bus.push_time  = '0;
        bus.push_type  = dteNone;
        bus.push_diag  = '0;
        bus.push_data  = '0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_data   = '0;
        bus.rep_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rstPushReady", 64'(bus.push_ready), 1);
        check("rstReqValid", 64'(bus.req_valid), 0);
        check("rstRepValid", 64'(bus.rep_valid), 0);
        check("rstCount", 64'(bus.count), 0);
        check("rstTicks", bus.ticks, 0);
        check("rstTimeout", 64'(bus.timeout), 0);
        reset = 1'b0;

        // due-now request, latency and reply capture
        while (mTicks < 5) step();
        push(0, dteDiagFunc, 7'o71, 36'o000000000017, 1);
        check("cnt1", 64'(bus.count), 1);
        check("lat0", 64'(bus.req_valid), 0);
        step();
        check("lat1", 64'(bus.req_valid), 0);
        step();
        check("lat2", 64'(bus.req_valid), 1);
        serve(36'o123456654321, 1);
        check("ticks", bus.ticks, mTicks);

        // future release
        push(100, dteDiagRead, 7'o12, 36'o0, 1);
        early = 1'b0;
        while (mTicks <= 100) begin
            if (bus.req_valid) early = 1'b1;
            step();
        end
        check("earlyRel", 64'(early), 0);
        check("relAt101", 64'(bus.req_valid), 1);
        serve(36'o777000111222, 1);

        // full queue, rejected push, in-order drain
        for (int i = 0; i < DEPTH; i++) begin
            push(0, (i % 2) ? dteMisc : dteDiagWrite,
                 7'(i + 1), 36'(i * 3 + 5), 1);
        end
        check("fullCnt", 64'(bus.count), DEPTH);
        check("fullRdy", 64'(bus.push_ready), 0);
        push(0, dteReleaseEBUSData, 7'o177, 36'o1, 0);
        check("fullNoPush", 64'(bus.count), DEPTH);
        for (int i = 0; i < DEPTH; i++) serve(36'(1000 + i), 1);
        check("drainCnt", 64'(bus.count), 0);
        check("drainRdy", 64'(bus.push_ready), 1);

        // reply backpressure
        push(0, dteMisc, 7'o5, 36'o11, 1);
        push(0, dteDiagRead, 7'o6, 36'o22, 1);
        serve(36'o33, 0);
        held = 1'b0;
        repeat (5) begin
            if (bus.req_valid) held = 1'b1;
            step();
        end
        check("bpNoIssue", 64'(held), 0);
        check("bpRepHeld", 64'(bus.rep_valid), 1);
        bus.rep_ack = 1'b1;
        step();
        bus.rep_ack = 1'b0;
        check("bpRelease", 64'(bus.req_valid), 1);
        check("bpRepClr", 64'(bus.rep_valid), 0);
        serve(36'o44, 1);

`ifdef DTE_REQ_TIMEOUT_EN
        push(0, dteDiagFunc, 7'o3, 36'o7, 1);
        waitReq(16);
        eTmo = sb.pop_front();
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        repeat (TMO - 1) step();
        check("tmoEarly", 64'(bus.rep_valid), 0);
        step();
        check("tmoRep", 64'(bus.rep_valid), 1);
        check("tmoData", 64'(bus.rep_data), 0);
        check("tmoType", 64'(bus.rep_type), 64'(eTmo.reqType));
        check("tmoFlag", 64'(bus.timeout), 1);
        bus.rep_ack = 1'b1;
        step();
        bus.rep_ack = 1'b0;
        push(0, dteDiagWrite, 7'o4, 36'o55, 1);
        serve(36'o66, 1);
        check("tmoSticky", 64'(bus.timeout), 1);
`else
        check("tmoTied", 64'(bus.timeout), 0);
`endif

        // reset while waiting for a reply
        push(0, dteDiagRead, 7'o1, 36'o2, 1);
        push(0, dteMisc, 7'o2, 36'o3, 1);
        waitReq(16);
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        sb.delete();
        reset = 1'b1;
        #1;
        check("mrRepValid", 64'(bus.rep_valid), 0);
        check("mrReqValid", 64'(bus.req_valid), 0);
        check("mrCount", 64'(bus.count), 0);
        check("mrTicks", bus.ticks, 0);
        check("mrPushRdy", 64'(bus.push_ready), 1);
        check("mrTimeout", 64'(bus.timeout), 0);
        step();
        reset = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 36'o5;
        step();
        bus.rsp_valid = 1'b0;
        step();
        check("mrRspIgn", 64'(bus.rep_valid), 0);
        check("mrNoReq", 64'(bus.req_valid), 0);
        check("mrTicksRun", bus.ticks, mTicks);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
